// File: rtl/cla_multiword_add_ctrl_pkg.sv
// Shared definitions for the multi-word CLA sequencer: state encoding and index width helper.
package cla_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // StSpare is unreachable in normal operation and behaves as StIdle.
  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StRun   = ST_RUN,
    StDone  = ST_DONE,
    StSpare = 2'd3
  } state_e;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cla_multiword_add_ctrl_if.sv
// Operand-in / result-out valid-ready bundle for the multi-word CLA sequencer.
interface cla_multiword_add_ctrl_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/cla_multiword_add_ctrl_cla.sv
// Purely combinational N-bit carry-lookahead adder; every carry is a flat sum of products.
module carry_lookahead_adder #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;
  logic         prop_run;
  logic         carry_acc;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, built without reading earlier carries.
  always_comb begin
    carry     = '0;
    prop_run  = 1'b1;
    carry_acc = 1'b0;
    carry[0]  = cin_i;
    for (int i = 0; i < int'(N); i++) begin
      prop_run  = 1'b1;
      carry_acc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        carry_acc = carry_acc | (gen[j] & prop_run);
        prop_run  = prop_run & prop[j];
      end
      carry[i+1] = carry_acc | (prop_run & cin_i);
    end
  end

  assign sum_o  = prop ^ carry[N-1:0];
  assign cout_o = carry[N];

endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// Performs N*WORDS-bit adds by stepping one N-bit CLA across the operand slices, LSB first.
module cla_multiword_add_ctrl
  import cla_ctrl_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cla_multiword_add_ctrl_if.slave  bus,
  output logic                     busy
);

  localparam int unsigned    IdxW    = idx_width(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [WORDS-1:0][N-1:0]   op_a_q, op_a_d;
  logic [WORDS-1:0][N-1:0]   op_b_q, op_b_d;
  logic [WORDS-1:0][N-1:0]   sum_q, sum_d;
  logic                      carry_q, carry_d;
  logic                      cout_q, cout_d;

  logic [N-1:0]              slice_a;
  logic [N-1:0]              slice_b;
  logic [N-1:0]              slice_sum;
  logic                      slice_cout;

  assign slice_a = op_a_q[idx_q];
  assign slice_b = op_b_q[idx_q];

  carry_lookahead_adder #(
    .N (N)
  ) u_cla (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      StRun: begin
        sum_d[idx_q] = slice_sum;
        carry_d      = slice_cout;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        // StIdle, and the spare encoding treated identically.
        state_d = StIdle;
        if (bus.in_valid) begin
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake outputs come from the state register alone.
  always_comb begin
    bus.in_ready  = (state_q != StRun) && (state_q != StDone);
    bus.out_valid = (state_q == StDone);
    busy          = (state_q == StRun) || (state_q == StDone);
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Directed table, backpressure/reset sequences and a randomized scoreboard run.
module tb_cla_multiword_add_ctrl;

  localparam int unsigned N     = 16;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = N * WORDS;
  localparam int unsigned WP    = W + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_multiword_add_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();

  cla_multiword_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [WP-1:0] got, input logic [WP-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Accept one operation, scramble the operand bus afterwards, wait (bounded) for out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output logic [W-1:0] s, output logic c, output int lat);
    @(negedge clk);
    check1("accept_in_ready", bus.in_ready, 1'b1);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    bus.cin      = ~cin;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    s = bus.sum;
    c = bus.cout;
  endtask

  vec_t         vecs [7];
  logic [W-1:0] s;
  logic         c;
  logic [W-1:0] held_sum;
  logic         held_cout;
  int           lat;
  logic [W:0]   expq [$];
  logic [W:0]   exp_val;
  int           done_ops;
  int           cyc;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rc;

  initial begin
    vecs[0] = '{64'd10, 64'd5, 1'b0, 64'd15, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
    vecs[5] = '{64'd0, 64'd0, 1'b1, 64'd1, 1'b0};
    vecs[6] = '{64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'h0001_0000_0000_0000, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_cout", bus.cout, 1'b0);
    check("rst_sum", WP'(bus.sum), '0);

    // Directed table with the sink always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
      check($sformatf("vec%0d_latency", i), WP'(lat), WP'(WORDS));
      check($sformatf("vec%0d_sum", i), WP'(s), WP'(vecs[i].sum));
      check1($sformatf("vec%0d_cout", i), c, vecs[i].cout);
      @(posedge clk);
      @(negedge clk);
      check1($sformatf("vec%0d_idle_ready", i), bus.in_ready, 1'b1);
      check1($sformatf("vec%0d_valid_drop", i), bus.out_valid, 1'b0);
    end

    // Backpressure: hold DONE for five cycles, results must not move.
    bus.out_ready = 1'b0;
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, s, c, lat);
    check("bp_latency", WP'(lat), WP'(WORDS));
    check("bp_sum", WP'(s), WP'(64'h2222_2222_2222_2212));
    check1("bp_cout", c, 1'b0);
    held_sum  = s;
    held_cout = c;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check1($sformatf("bp%0d_valid", k), bus.out_valid, 1'b1);
      check1($sformatf("bp%0d_in_ready", k), bus.in_ready, 1'b0);
      check1($sformatf("bp%0d_busy", k), busy, 1'b1);
      check($sformatf("bp%0d_sum", k), WP'(bus.sum), WP'(held_sum));
      check1($sformatf("bp%0d_cout", k), bus.cout, held_cout);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1("bp_release_in_ready", bus.in_ready, 1'b1);
    check1("bp_release_valid", bus.out_valid, 1'b0);
    check1("bp_release_busy", busy, 1'b0);

    // Reset in RUN with idx=2, then rerun.
    bus.a        = 64'd10;
    bus.b        = 64'd5;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check1("mid_run_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check1("midrst_out_valid", bus.out_valid, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_sum", WP'(bus.sum), '0);
    run_op(64'd10, 64'd5, 1'b0, s, c, lat);
    check("rerun_sum", WP'(s), WP'(64'd15));
    check1("rerun_cout", c, 1'b0);
    @(posedge clk);

    // Randomized traffic against an in-order scoreboard.
    done_ops = 0;
    cyc      = 0;
    while (done_ops < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      check1("rand_ready_busy_excl", bus.in_ready & busy, 1'b0);
      ra = {$urandom(), $urandom()};
      rb = ($urandom_range(0, 3) == 0) ? ~ra : {$urandom(), $urandom()};
      rc = 1'($urandom_range(0, 1));
      bus.a         = ra;
      bus.b         = rb;
      bus.cin       = rc;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back({1'b0, ra} + {1'b0, rb} + WP'(rc));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_spurious_result: got %h expected none", {bus.cout, bus.sum});
        end else begin
          exp_val = expq.pop_front();
          check("rand_result", {bus.cout, bus.sum}, exp_val);
        end
        done_ops++;
      end
    end
    check("rand_ops_done", WP'(done_ops), WP'(1000));
    check("rand_queue_empty", WP'(expq.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
